// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: state codes, ALU ops,
// immediate formats, datapath mux selects and opcode constants.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned OP_W    = 7;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_MULDIV, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LUI, S_AUIPC, S_TRAP
    } state_e;

    // Which ALU operation the FSM wants: fixed add/sub or decoded from funct fields
    typedef enum logic [1:0] {
        ALUM_ADD, ALUM_SUB, ALUM_FUNCT
    } alu_mode_e;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1001;

    localparam logic [IMM_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_W-1:0] IMM_J = 3'd3;
    localparam logic [IMM_W-1:0] IMM_U = 3'd4;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
    localparam logic [SEL_W-1:0] RES_MD     = 2'b11;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] F7_MULDIV = 7'b0000001;

    // Immediate format implied by the opcode
    function automatic logic [IMM_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

    // Branch condition from SUB flags; reserved funct3 codes never take
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lts, input logic ltu);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lts;
            3'b101:  return !lts;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALUControl decode from the FSM's ALU mode and funct fields.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_mode_e        mode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             is_rtype,
    output logic [ALU_W-1:0] alu_ctrl
);

    // Subtract only for R-type; funct7[5] also selects arithmetic right shift
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (mode)
            ALUM_SUB: alu_ctrl = ALU_SUB;
            ALUM_FUNCT: begin
                case (funct3)
                    3'b000: alu_ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32I(+M) control FSM: sequences fetch, decode, memory, ALU,
// mul/div, branch and jump steps and drives datapath enables and mux selects.
module multicycle_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_M      = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    input  logic [2:0]         Funct3,
    input  logic [6:0]         Funct7,
    input  logic               Zero,
    input  logic               LtS,
    input  logic               LtU,
    input  logic               mem_ready,
    input  logic               md_done,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               mem_req,
    output logic               md_start,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic               AdrSrc,
    output logic [ALU_W-1:0]   ALUControl,
    output logic [IMM_W-1:0]   ImmSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e    state_q, state_d;
    logic      illegal_q;
    logic      md_issued_q;
    logic      jmp_second_q;
    logic      mem_done;
    alu_mode_e alu_mode;

    assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state    = state_q;
    assign illegal  = illegal_q;
    assign ImmSrc   = imm_src_of(Op);

    mc_alu_decoder u_alu_dec (
        .mode     (alu_mode),
        .funct3   (Funct3),
        .funct7_5 (Funct7[5]),
        .is_rtype (Op == OP_RTYPE),
        .alu_ctrl (ALUControl)
    );

    // State register plus sticky trap flag, mul/div issue flag and jump phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            illegal_q    <= 1'b0;
            md_issued_q  <= 1'b0;
            jmp_second_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_q    <= illegal_q | (state_d == S_TRAP);
            md_issued_q  <= (state_q == S_MULDIV) && (state_d == S_MULDIV);
            jmp_second_q <= ((state_q == S_JAL) || (state_q == S_JALR)) && !jmp_second_q;
        end
    end

    // Next state and datapath controls; write enables forced low while in reset
    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        mem_req   = 1'b0;
        md_start  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        AdrSrc    = ADR_PC;
        alu_mode  = ALUM_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (Funct7 == F7_MULDIV) state_d = ENABLE_M ? S_MULDIV : S_TRAP;
                        else                     state_d = S_EXECR;
                    end
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = ADR_RESULT;
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                AdrSrc  = ADR_RESULT;
                if (mem_done) begin
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_DATA;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA  = SRCA_RD1;
                alu_mode = ALUM_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                alu_mode = ALUM_FUNCT;
                state_d  = S_ALUWB;
            end
            S_MULDIV: begin
                md_start = !md_issued_q;
                if (md_done) begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_MD;
                    state_d   = S_FETCH;
                end
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RD1;
                alu_mode = ALUM_SUB;
                if (Funct3 == 3'b010 || Funct3 == 3'b011) begin
                    state_d = S_TRAP;
                end else begin
                    PCWrite = branch_taken(Funct3, Zero, LtS, LtU);
                    state_d = S_FETCH;
                end
            end
            // First cycle writes the link OldPC+4; second recomputes the target into PC
            S_JAL, S_JALR: begin
                ResultSrc = RES_ALU;
                if (!jmp_second_q) begin
                    ALUSrcA  = SRCA_OLDPC;
                    ALUSrcB  = SRCB_FOUR;
                    RegWrite = 1'b1;
                end else begin
                    ALUSrcA = (state_q == S_JAL) ? SRCA_OLDPC : SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            md_start = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_ctrl_unit.md
MULTICYCLE_CTRL_UNIT -- requirements
Module: multicycle_ctrl_unit

Interface
REQ-001 SHALL have parameter ENABLE_M, default 1; 1 = RV32M ops (Op=0110011, Funct7=0000001) sequenced through MULDIV, 0 = such ops illegal.
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = MEMREAD/MEMWRITE/FETCH hold until mem_ready, 0 = mem_ready ignored, one cycle per access.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports Op/Funct3/Funct7  input  7/3/7  instruction fields from IR.
REQ-006 SHALL have ports Zero/LtS/LtU  input  1 each  ALU flags from SUB: equal, signed less, unsigned less.
REQ-007 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-008 SHALL have port md_done  input  1  mul/div unit result valid.
REQ-009 SHALL have ports PCWrite/RegWrite/MemWrite/IRWrite  output  1 each  register write enables.
REQ-010 SHALL have port mem_req  output  1  memory access request.
REQ-011 SHALL have port md_start  output  1  one-cycle mul/div start pulse.
REQ-012 SHALL have ports ResultSrc/ALUSrcA/ALUSrcB  output  2 each  datapath muxes.
REQ-013 SHALL have port AdrSrc  output  1  0 = PC, 1 = Result.
REQ-014 SHALL have ports ALUControl/ImmSrc  output  4/3  ALU op, immediate format (I,S,B,J,U = 0..4).
REQ-015 SHALL have ports illegal/state  output  1/4  sticky illegal flag, current state code.

Function
REQ-016 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, MULDIV, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
REQ-017 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00(PC), ALUSrcB=10(+4), ResultSrc=10; IRWrite and PCWrite asserted only in the cycle mem_ready=1 (always, if MEM_HANDSHAKE=0), then -> DECODE.
REQ-018 DECODE: ALUSrcA=01(OldPC), ALUSrcB=01(Imm), ALU=ADD; next by Op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR or MULDIV, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, 0010111 -> AUIPC, other -> TRAP.
REQ-019 MEMADR: ALUSrcA=10(RD1), ALUSrcB=01, ADD; load -> MEMREAD, store -> MEMWRITE.
REQ-020 MEMREAD/MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00; MemWrite asserted only in the cycle mem_ready=1; exit to MEMWB / FETCH on that cycle.
REQ-021 MEMWB, ALUWB: RegWrite=1 one cycle, ResultSrc=01 / 00 respectively, -> FETCH.
REQ-022 EXECR/EXECI: ALUSrcA=10, ALUSrcB=00 / 01; ALUControl from Funct3/Funct7: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001; SUB only for R-type Funct7[5]=1; -> ALUWB.
REQ-023 MULDIV: md_start=1 on entry cycle only; wait for md_done; on md_done RegWrite=1, ResultSrc=11, -> FETCH; md_done in entry cycle accepted.
REQ-024 BRANCH: ALU=SUB, RD1 vs RD2; PCWrite=1 when taken (BEQ Zero, BNE !Zero, BLT LtS, BGE !LtS, BLTU LtU, BGEU !LtU); Funct3 010/011 -> TRAP; else -> FETCH.
REQ-025 JAL/JALR: RegWrite rd=OldPC+4, PCWrite=1 with target OldPC+imm / (RD1+imm) with bit0 cleared by datapath; two cycles, -> FETCH.
REQ-026 LUI/AUIPC: ImmSrc=U; result imm / OldPC+imm; -> ALUWB.
REQ-027 TRAP: illegal set to 1 and held; no write enable asserted; FSM remains in TRAP until reset.
REQ-028 All outputs SHALL be combinational from state and inputs only; no output glitch-dependent path from mem_ready to state other than the listed gating.

Reset
REQ-029 reset low SHALL asynchronously force state=FETCH, illegal=0, md_start=0; all write enables 0 while reset low.
REQ-030 reset asserted mid-access or mid-MULDIV SHALL abandon the operation; first cycle after release is FETCH with mem_req=1.

Structure
REQ-031 State codes, ALUControl codes, ImmSrc codes, mux select codes and opcode constants SHALL live in a shared package mc_ctrl_pkg.
REQ-032 ALUControl decode SHALL be one combinational sub-module mc_alu_decoder; FSM and output logic stay in the top.

Verification
REQ-033 ADDI x1,x0,5 with MEM_HANDSHAKE=0 -> FETCH,DECODE,EXECI,ALUWB,FETCH; RegWrite high exactly in ALUWB, ALUControl=0000.
REQ-034 LW with mem_ready low 3 cycles in MEMREAD -> state holds MEMREAD 4 cycles, RegWrite only in MEMWB, total 8 cycles.
REQ-035 BNE with Zero=1 -> PCWrite low in BRANCH; with Zero=0 -> PCWrite high one cycle.
REQ-036 MUL with md_done after 5 cycles -> md_start single pulse, RegWrite with ResultSrc=11 on md_done cycle; ENABLE_M=0 -> TRAP, illegal=1.
REQ-037 Op=1111111 -> TRAP, illegal stays 1 for 10 cycles; reset pulse low mid-MEMWRITE -> FETCH, MemWrite never asserted.
